dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between the single-cycle core (MemWrite/ALUOut/rd2_Data/ReadData path) and a host/debug port used for program-data loading and readback.
- Sits between mips and the data RAM.
- Drives a stall to the core whenever the core's access cannot complete in the current cycle.
- Bounded host starvation via a wait counter.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous data RAM between the core and a host/debug port.
// Optional macro DMEM_ARB_PERF_EN adds saturating stall_cycles / host_grants counters.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       host_grants
`endif
);

  typedef enum logic [1:0] {IDLE, CPU_RDW, HOST_RDW} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_sel;
  logic              host_grant;
  logic [3:0]        wait_inc;

  assign host_sel   = host_req & (~cpu_req | (wait_cnt_q >= 4'(STARVE_LIMIT)));
  assign host_grant = (state_q == IDLE) & host_sel;
  assign wait_inc   = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_rdata    = cpu_rdata_q;
    host_rdata   = host_rdata_q;
    cpu_stall    = 1'b0;
    host_ack     = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (host_sel) begin
          mem_en     = 1'b1;
          mem_we     = host_we;
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
          cpu_stall  = cpu_req;
          wait_cnt_d = 4'd0;
          if (host_we) host_ack = 1'b1;
          else         state_d  = HOST_RDW;
        end else begin
          wait_cnt_d = host_req ? wait_inc : 4'd0;
          if (cpu_req) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
              cpu_stall = 1'b1;
              state_d   = CPU_RDW;
            end
          end
        end
      end
      // The held cpu_req completes here; it is not reissued as a new access.
      CPU_RDW: begin
        cpu_rdata   = mem_rdata;
        cpu_rdata_d = mem_rdata;
        wait_cnt_d  = host_req ? wait_inc : 4'd0;
        state_d     = IDLE;
      end
      HOST_RDW: begin
        host_ack     = 1'b1;
        host_rdata   = mem_rdata;
        host_rdata_d = mem_rdata;
        cpu_stall    = cpu_req;
        wait_cnt_d   = 4'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low while reset is asserted, without waiting for a clock edge.
    if (!rst) begin
      cpu_rdata  = '0;
      host_rdata = '0;
      cpu_stall  = 1'b0;
      host_ack   = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cycles_q, host_grants_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 16'd0;
      host_grants_q  <= 16'd0;
    end else begin
      if (cpu_stall && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
      if (host_grant && host_grants_q != 16'hFFFF) host_grants_q <= host_grants_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign host_grants  = host_grants_q;
`else
  logic unused_grant;
  assign unused_grant = host_grant;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, host_addr, host_wdata, host_rdata;
  logic       cpu_stall, host_ack, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cycles, host_grants;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ram [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .stall_cycles(stall_cycles), .host_grants(host_grants)
`endif
  );

  // Single-port synchronous RAM, read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;

    // Reset holds every output low even with a request present
    #2;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    tick();
    rst = 1'b1;

    // CPU write completes in the same cycle
    settle();
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    chk("wr_stall", cpu_stall, 0);
    tick();

    // CPU read: one stall cycle, data on the next
    cpu_we = 1'b0;
    settle();
    chk("rd_issue_stall", cpu_stall, 1);
    chk("rd_issue_en", mem_en, 1);
    chk("rd_issue_we", mem_we, 0);
    exp_q.push_back(8'hA5);
    tick();
    settle();
    chk("rd_done_stall", cpu_stall, 0);
    chk("rd_done_en", mem_en, 0);
    chk("rd_done_data", cpu_rdata, pop_exp());
    tick();
    cpu_req = 1'b0;
    settle();
    chk("rd_hold_data", cpu_rdata, 8'hA5);
    tick();

    // Host read then back-to-back host write
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    settle();
    chk("hrd_issue_en", mem_en, 1);
    chk("hrd_issue_ack", host_ack, 0);
    exp_q.push_back(8'hA5);
    tick();
    settle();
    chk("hrd_ack", host_ack, 1);
    chk("hrd_data", host_rdata, pop_exp());
    tick();
    host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
    settle();
    chk("hwr_ack", host_ack, 1);
    chk("hwr_mem_we", mem_we, 1);
    chk("hwr_addr", mem_addr, 8'h20);
    tick();
    host_we = 1'b0;
    settle();
    chk("hrb_ack_issue", host_ack, 0);
    chk("hrb_hold_data", host_rdata, 8'hA5);
    exp_q.push_back(8'h3C);
    tick();
    settle();
    chk("hrb_data", host_rdata, pop_exp());
    tick();
    host_req = 1'b0;

    // Starvation: fresh reset so perf counters start at zero
    rst = 1'b0; #1; rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("starve%0d_ack", c), host_ack, 0);
      chk($sformatf("starve%0d_addr", c), mem_addr, 8'h40);
      tick();
    end
    settle();
    chk("starve_wait_cnt", dut.wait_cnt_q, 4);
    chk("starve_grant_ack", host_ack, 1);
    chk("starve_grant_stall", cpu_stall, 1);
    chk("starve_grant_addr", mem_addr, 8'h30);
    chk("starve_grant_wdata", mem_wdata, 8'h77);
    tick();
    host_req = 1'b0;
    settle();
    chk("starve_resume_stall", cpu_stall, 0);
    chk("starve_resume_addr", mem_addr, 8'h40);
    tick();
    cpu_req = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    settle();
    chk("perf_host_grants", host_grants, 1);
    chk("perf_stall_cycles", stall_cycles, 1);
`endif

    // Reset asserted in the middle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    settle();
    chk("rrst_issue_stall", cpu_stall, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rrst_mem_en", mem_en, 0);
    chk("rrst_stall", cpu_stall, 0);
    chk("rrst_ack", host_ack, 0);
    chk("rrst_cpu_rdata", cpu_rdata, 0);
    tick();
    rst = 1'b1;
    settle();
    chk("rrst_reissue_stall", cpu_stall, 1);
    chk("rrst_reissue_en", mem_en, 1);
    exp_q.push_back(8'hA5);
    tick();
    settle();
    chk("rrst_rd_data", cpu_rdata, pop_exp());
    chk("rrst_rd_stall", cpu_stall, 0);
    tick();
    cpu_req = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
